// File: rtl/sm_debug_responder_pkg.sv
// Command-byte layout, FSM encoding and response constants for the debug responder.
// Shared by the top FSM and the byte serializer; echo feature guarded by SM_DEBUG_ECHO_EN.
package sm_debug_responder_pkg;

  localparam int CMD_SPACE = 7;
  localparam int CMD_BURST = 6;
  localparam int CMD_RSVD  = 5;

  localparam logic [7:0] ERR_BYTE = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ECHO,
    ST_ADDR,
    ST_WAIT,
    ST_SEND
  } state_t;

  function automatic logic [31:0] byte_word(input logic [7:0] b);
    return {24'h0, b};
  endfunction

endpackage

// File: rtl/sm_debug_serializer.sv
// Loads a snapshot word (or one byte) and emits it LSB-first on valid/ready with no gaps.
// o_done pulses combinationally with the handshake of the final byte; a load wins over a shift.
module sm_debug_serializer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [31:0] i_word,
  input  logic [2:0]  i_nbytes,
  output logic        o_vld,
  input  logic        i_rdy,
  output logic [7:0]  o_dat,
  output logic        o_done
);

  logic [31:0] r_word;
  logic [2:0]  r_cnt;
  logic        w_fire;

  assign o_vld  = (r_cnt != 3'd0);
  assign o_dat  = r_word[7:0];
  assign w_fire = o_vld & i_rdy;
  assign o_done = w_fire & (r_cnt == 3'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_word <= i_word;
      r_cnt  <= i_nbytes;
    end else if (w_fire) begin
      r_word <= {8'h00, r_word[31:8]};
      r_cnt  <= r_cnt - 3'd1;
    end
  end

endmodule

// File: rtl/sm_debug_responder.sv
// Debug read responder: 1-byte commands in, register/RAM words out as little-endian bytes.
// Define SM_DEBUG_ECHO_EN to prefix every response with a copy of its command byte.
module sm_debug_responder
  import sm_debug_responder_pkg::*;
#(
  parameter int READ_LAT  = 1,
  parameter int BURST_LEN = 16,
  parameter int ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [7:0]        req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_data,
  output logic              busy,
  output logic [ADDR_W-1:0] regAddr,
  input  logic [31:0]       regData,
  output logic [ADDR_W-1:0] ramAddrB,
  input  logic [31:0]       ramDataB
);

  localparam int WCNT_W = $clog2(BURST_LEN) + 1;
  localparam int WAIT_W = 8;
  localparam logic [WAIT_W-1:0] WAIT_INIT  = (READ_LAT > 0) ? WAIT_W'(READ_LAT - 1) : '0;
  localparam logic [WCNT_W-1:0] BURST_INIT = WCNT_W'(BURST_LEN - 1);

  state_t              r_state, w_next;
  logic                r_req_rdy, r_space, r_rsvd;
  logic [ADDR_W-1:0]   r_addr, r_reg_addr, r_ram_addr;
  logic [WCNT_W-1:0]   r_words;
  logic [WAIT_W-1:0]   r_wait;
  logic                w_accept, w_ser_done, w_load, w_step;
  logic [31:0]         w_load_word, w_rd_word;
  logic [2:0]          w_load_n;
  logic [ADDR_W-1:0]   w_addr_inc;

  assign w_accept   = req_valid & r_req_rdy;
  assign w_rd_word  = r_space ? ramDataB : regData;
  assign w_addr_inc = r_addr + ADDR_W'(1);
  assign w_step     = (r_state == ST_SEND) & w_ser_done & !r_rsvd & (r_words != '0);

  assign req_ready = r_req_rdy;
  assign busy      = (r_state != ST_IDLE);
  assign regAddr   = r_reg_addr;
  assign ramAddrB  = r_ram_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_req_rdy <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_req_rdy <= (w_next == ST_IDLE);
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept) begin
`ifdef SM_DEBUG_ECHO_EN
        w_next = ST_ECHO;
`else
        w_next = req_data[CMD_RSVD] ? ST_SEND : ST_ADDR;
`endif
      end
      ST_ECHO: if (w_ser_done) w_next = r_rsvd ? ST_SEND : ST_ADDR;
      ST_ADDR: w_next = (READ_LAT == 0) ? ST_SEND : ST_WAIT;
      ST_WAIT: if (r_wait == '0) w_next = ST_SEND;
      ST_SEND: if (w_ser_done) w_next = w_step ? ST_ADDR : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Serializer loads: the captured word lands on the edge that leaves ADDR/WAIT.
  always_comb begin
    w_load      = 1'b0;
    w_load_word = '0;
    w_load_n    = 3'd4;
    case (r_state)
      ST_IDLE: if (w_accept) begin
`ifdef SM_DEBUG_ECHO_EN
        w_load      = 1'b1;
        w_load_word = byte_word(req_data);
        w_load_n    = 3'd1;
`else
        if (req_data[CMD_RSVD]) begin
          w_load      = 1'b1;
          w_load_word = byte_word(ERR_BYTE);
          w_load_n    = 3'd1;
        end
`endif
      end
      ST_ECHO: if (w_ser_done && r_rsvd) begin
        w_load      = 1'b1;
        w_load_word = byte_word(ERR_BYTE);
        w_load_n    = 3'd1;
      end
      ST_ADDR: if (READ_LAT == 0) begin
        w_load      = 1'b1;
        w_load_word = w_rd_word;
      end
      ST_WAIT: if (r_wait == '0) begin
        w_load      = 1'b1;
        w_load_word = w_rd_word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait <= '0;
    end else if (w_next == ST_WAIT && r_state != ST_WAIT) begin
      r_wait <= WAIT_INIT;
    end else if (r_state == ST_WAIT && r_wait != '0) begin
      r_wait <= r_wait - WAIT_W'(1);
    end
  end

  // Only the port selected by the command moves; the other keeps its last address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_space    <= 1'b0;
      r_rsvd     <= 1'b0;
      r_addr     <= '0;
      r_words    <= '0;
      r_reg_addr <= '0;
      r_ram_addr <= '0;
    end else if (w_accept) begin
      r_space <= req_data[CMD_SPACE];
      r_rsvd  <= req_data[CMD_RSVD];
      r_addr  <= req_data[ADDR_W-1:0];
      r_words <= req_data[CMD_BURST] ? BURST_INIT : '0;
      if (!req_data[CMD_RSVD]) begin
        if (req_data[CMD_SPACE]) r_ram_addr <= req_data[ADDR_W-1:0];
        else                     r_reg_addr <= req_data[ADDR_W-1:0];
      end
    end else if (w_step) begin
      r_addr  <= w_addr_inc;
      r_words <= r_words - WCNT_W'(1);
      if (r_space) r_ram_addr <= w_addr_inc;
      else         r_reg_addr <= w_addr_inc;
    end
  end

  sm_debug_serializer u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_word   (w_load_word),
    .i_nbytes (w_load_n),
    .o_vld    (rsp_valid),
    .i_rdy    (rsp_ready),
    .o_dat    (rsp_data),
    .o_done   (w_ser_done)
  );

endmodule

// File: tb/tb_sm_debug_responder.sv
// Directed bench for sm_debug_responder (READ_LAT=1, BURST_LEN=16); follows SM_DEBUG_ECHO_EN.
module tb_sm_debug_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_data = 8'h00;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_data;
  logic        busy;
  logic [4:0]  regAddr, ramAddrB;
  logic [31:0] regData, ramDataB;

  logic [31:0] rf  [32];
  logic [31:0] ram [32];
  logic [7:0]  rx_buf [$];
  logic [7:0]  exp_q  [$];
  int          n_checks = 0;
  int          n_errs   = 0;

  always #5 clk = ~clk;

  // Synchronous one-cycle read ports, matching READ_LAT=1.
  always @(posedge clk) begin
    regData  <= rf[regAddr];
    ramDataB <= ram[ramAddrB];
  end

  sm_debug_responder #(.READ_LAT(1), .BURST_LEN(16), .ADDR_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .regAddr   (regAddr),
    .regData   (regData),
    .ramAddrB  (ramAddrB),
    .ramDataB  (ramDataB)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
  endtask

  task automatic push_echo(input logic [7:0] c);
`ifdef SM_DEBUG_ECHO_EN
    exp_q.push_back(c);
`else
    if (c === 8'hxx) exp_q.push_back(c);
`endif
  endtask

  // Called at a negedge; returns at the negedge after the last handshake edge.
  task automatic run_rx(input int n, input bit toggle);
    int         cyc = 0;
    bit         stalled = 1'b0;
    logic [7:0] held = 8'h00;
    rx_buf.delete();
    while (rx_buf.size() < n && cyc < 600) begin
      if (stalled) begin
        chk("stall_vld", 32'(rsp_valid), 32'd1);
        chk("stall_dat", 32'(rsp_data), 32'(held));
        stalled = 1'b0;
      end
      rsp_ready = toggle ? ~rsp_ready : 1'b1;
      if (rsp_valid) begin
        if (rsp_ready) rx_buf.push_back(rsp_data);
        else begin
          stalled = 1'b1;
          held    = rsp_data;
        end
      end
      @(negedge clk);
      cyc++;
    end
    rsp_ready = 1'b0;
    chk("rx_count", 32'(rx_buf.size()), 32'(n));
  endtask

  task automatic cmp_rx(input string tag, input int n);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_b%0d", tag, i),
          (i < rx_buf.size()) ? 32'(rx_buf[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
  endtask

  task automatic send_cmd(input logic [7:0] c);
    int k = 0;
    while (!req_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_rdy", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_data  = c;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_vld"},  32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [4:0] a;
    logic [7:0] b;
    for (int i = 0; i < 32; i++) begin
      b      = 8'(i);
      rf[i]  = {8'h5A, b, 8'hA5, b};
      ram[i] = {b + 8'hC0, b + 8'h80, b + 8'h40, b};
    end
    rf[0] = 32'h0040_1A2C;
    rf[1] = 32'h1122_3344;
    rf[2] = 32'h1234_5678;
    rf[5] = 32'hA1B2_C3D4;

    // Reset values
    repeat (4) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data",  32'(rsp_data),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_regAddr",   32'(regAddr),   32'd0);
    chk("rst_ramAddrB",  32'(ramAddrB),  32'd0);
    rst_n = 1'b1;
    chk("rel_rdy_before_edge", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("rel_rdy_after_edge", 32'(req_ready), 32'd1);

    // Single register read with latency check
    exp_q.delete();
    push_echo(8'h02);
    push_word(32'h1234_5678);
    send_cmd(8'h02);
    chk("reg_addr", 32'(regAddr), 32'd2);
    chk("ram_addr_hold", 32'(ramAddrB), 32'd0);
`ifndef SM_DEBUG_ECHO_EN
    chk("lat_t0", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("lat_t1", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("lat_t2", 32'(rsp_valid), 32'd1);
`endif
    run_rx(exp_q.size(), 1'b0);
    cmp_rx("reg", exp_q.size());
    chk_idle("reg_end");

    // RAM burst from 30 with wrap; a command during busy must be ignored
    exp_q.delete();
    push_echo(8'hDE);
    for (int w = 0; w < 16; w++) begin
      a = 5'(30 + w);
      push_word(ram[a]);
    end
    send_cmd(8'hDE);
    req_valid = 1'b1;
    req_data  = 8'h03;
    chk("busy_during", 32'(busy), 32'd1);
    chk("rdy_during", 32'(req_ready), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    run_rx(exp_q.size(), 1'b0);
    cmp_rx("burst", exp_q.size());
    chk_idle("burst_end");
    chk("burst_ram_addr", 32'(ramAddrB), 32'd13);
    chk("burst_reg_hold", 32'(regAddr), 32'd2);

    // Backpressure with a snapshot change after capture
    exp_q.delete();
    push_echo(8'h05);
    push_word(32'hA1B2_C3D4);
    send_cmd(8'h05);
`ifndef SM_DEBUG_ECHO_EN
    @(negedge clk);
    @(negedge clk);
    rf[5] = 32'hDEAD_BEEF;
`endif
    run_rx(exp_q.size(), 1'b1);
    cmp_rx("bp", exp_q.size());
    chk_idle("bp_end");

    // Reserved bit: error byte only, no address movement
    exp_q.delete();
    push_echo(8'h20);
    exp_q.push_back(8'hEE);
    send_cmd(8'h20);
    chk("err_reg_hold", 32'(regAddr), 32'd5);
    chk("err_ram_hold", 32'(ramAddrB), 32'd13);
    run_rx(exp_q.size(), 1'b0);
    cmp_rx("err", exp_q.size());
    chk_idle("err_end");
    chk("err_reg_after", 32'(regAddr), 32'd5);
    chk("err_ram_after", 32'(ramAddrB), 32'd13);

    // Abort a register burst after two bytes
    exp_q.delete();
    push_echo(8'h41);
    push_word(32'h1122_3344);
    send_cmd(8'h41);
    run_rx(2, 1'b0);
    cmp_rx("abort", 2);
    rst_n = 1'b0;
    #1;
    chk("abort_vld", 32'(rsp_valid), 32'd0);
    chk("abort_dat", 32'(rsp_data), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_reg", 32'(regAddr), 32'd0);
    chk("abort_rdy", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // PC read after abort
    exp_q.delete();
    push_echo(8'h00);
    push_word(32'h0040_1A2C);
    send_cmd(8'h00);
    run_rx(exp_q.size(), 1'b0);
    cmp_rx("pc", exp_q.size());
    chk_idle("pc_end");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
